// File: rtl/proc_mem_responder_pkg.sv
// Shared types and helpers for the processor memory responder: 4-byte request and
// response messages, request type codes and byte-lane helpers.
package proc_mem_responder_pkg;

  localparam int unsigned c_req_w  = 77;
  localparam int unsigned c_resp_w = 47;

  localparam logic [2:0] c_type_read  = 3'd0;
  localparam logic [2:0] c_type_write = 3'd1;
  localparam logic [2:0] c_type_init  = 3'd2;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // Lanes offset..offset+nbytes-1, clipped at byte 3 (len 0 means 4 bytes).
  function automatic logic [3:0] lane_mask(input logic [1:0] offset, input logic [1:0] len);
    logic [3:0] nbytes;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] m;
    nbytes = (len == 2'd0) ? 4'd4 : {2'b00, len};
    lo     = {2'b00, offset};
    hi     = lo + nbytes;
    m      = '0;
    for (int b = 0; b < 4; b++) begin
      m[b] = (4'(b) >= lo) && (4'(b) < hi);
    end
    return m;
  endfunction

  function automatic logic [31:0] expand_mask(input logic [3:0] m);
    logic [31:0] bm;
    bm = '0;
    for (int b = 0; b < 4; b++) begin
      bm[8*b +: 8] = {8{m[b]}};
    end
    return bm;
  endfunction

endpackage

// File: rtl/proc_mem_resp_queue.sv
// Parameterised val/rdy response FIFO; pointers wrap modulo depth so any depth >= 1 works.
module proc_mem_resp_queue
  import proc_mem_responder_pkg::*;
#(
  parameter int unsigned p_width = c_resp_w,
  parameter int unsigned p_depth = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enq_val,
  input  logic [p_width-1:0]             enq_msg,
  output logic                           deq_val,
  input  logic                           deq_rdy,
  output logic [p_width-1:0]             deq_msg,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(p_depth+1)-1:0]   count
);

  localparam int unsigned c_ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned c_cnt_w = $clog2(p_depth + 1);

  logic [p_width-1:0] entries [p_depth];
  logic [c_ptr_w-1:0] head;
  logic [c_ptr_w-1:0] tail;
  logic [c_cnt_w-1:0] count_next;
  logic               enq;
  logic               deq;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_ptr_w'(p_depth - 1)) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign enq     = enq_val && !full;
  assign deq     = deq_val && deq_rdy;
  assign deq_val = !empty;
  assign deq_msg = entries[head];

  always_comb begin
    count_next = count;
    if (enq && !deq) begin
      count_next = count + c_cnt_w'(1);
    end else if (!enq && deq) begin
      count_next = count - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (enq) tail <= ptr_inc(tail);
      if (deq) head <= ptr_inc(head);
      count <= count_next;
      full  <= (count_next == c_cnt_w'(p_depth));
      empty <= (count_next == '0);
    end
  end

  // Payload storage carries no reset; validity lives entirely in count/empty.
  always_ff @(posedge clk) begin
    if (enq) entries[tail] <= enq_msg;
  end

endmodule

// File: rtl/proc_mem_responder.sv
// Test/target memory answering 4-byte processor memory requests with in-order,
// fixed-latency responses buffered under backpressure.
module proc_mem_responder
  import proc_mem_responder_pkg::*;
#(
  parameter int unsigned p_num_words  = 256,
  parameter int unsigned p_latency    = 2,
  parameter int unsigned p_resp_depth = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  reqstream_val,
  output logic                                  reqstream_rdy,
  input  logic [76:0]                           reqstream_msg,
  output logic                                  respstream_val,
  input  logic                                  respstream_rdy,
  output logic [46:0]                           respstream_msg,
  output logic [$clog2(p_resp_depth+1)-1:0]     num_outstanding
);

  localparam int unsigned c_idx_w = $clog2(p_num_words);
  localparam int unsigned c_cnt_w = $clog2(p_resp_depth + 1);

  mem_req_4B_t        req;
  mem_resp_4B_t       resp_in;
  logic               accept;
  logic               dequeue;
  logic [c_idx_w-1:0] idx;
  logic [3:0]         lanes;
  logic [31:0]        bmask;
  logic [4:0]         shamt;
  logic [31:0]        rd_word;
  logic [31:0]        rd_data;
  logic [31:0]        wr_data;
  logic               is_wr;
  logic [c_cnt_w-1:0] cnt_next;

  logic [31:0]        storage [p_num_words];

  logic               pipe_val [p_latency];
  mem_resp_4B_t       pipe_msg [p_latency];

  logic [c_resp_w-1:0] q_deq_msg;
  logic                q_full;
  logic                q_empty;
  logic [c_cnt_w-1:0]  q_count;
  logic                unused;

  assign req     = reqstream_msg;
  assign accept  = reqstream_val && reqstream_rdy;
  assign dequeue = respstream_val && respstream_rdy;

  // Lane decode; upper address bits fall away so addresses wrap modulo storage size.
  assign idx     = req.addr[2 +: c_idx_w];
  assign lanes   = lane_mask(req.addr[1:0], req.len);
  assign bmask   = expand_mask(lanes);
  assign shamt   = {req.addr[1:0], 3'b000};
  assign rd_word = storage[idx];
  assign rd_data = (rd_word & bmask) >> shamt;
  assign wr_data = req.data << shamt;
  assign is_wr   = (req.typ == c_type_write) || (req.typ == c_type_init);

  always_comb begin
    resp_in        = '0;
    resp_in.typ    = req.typ;
    resp_in.opaque = req.opaque;
    resp_in.test   = 2'b00;
    resp_in.len    = req.len;
    if (req.typ == c_type_read) begin
      resp_in.data = rd_data;
    end
  end

  // Storage is never reset; writes land on the accept edge.
  always_ff @(posedge clk) begin
    if (accept && is_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) storage[idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < p_latency; i++) pipe_val[i] <= 1'b0;
    end else begin
      pipe_val[0] <= accept;
      for (int i = 1; i < p_latency; i++) pipe_val[i] <= pipe_val[i-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_msg[0] <= resp_in;
    for (int i = 1; i < p_latency; i++) pipe_msg[i] <= pipe_msg[i-1];
  end

  // Credit counter: queue room is guaranteed because outstanding never exceeds depth.
  always_comb begin
    cnt_next = num_outstanding;
    if (accept && !dequeue) begin
      cnt_next = num_outstanding + c_cnt_w'(1);
    end else if (!accept && dequeue) begin
      cnt_next = num_outstanding - c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_outstanding <= '0;
      reqstream_rdy   <= 1'b0;
    end else begin
      num_outstanding <= cnt_next;
      reqstream_rdy   <= (cnt_next < c_cnt_w'(p_resp_depth));
    end
  end

  proc_mem_resp_queue #(
    .p_width (c_resp_w),
    .p_depth (p_resp_depth)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .enq_val (pipe_val[p_latency-1]),
    .enq_msg (pipe_msg[p_latency-1]),
    .deq_val (respstream_val),
    .deq_rdy (respstream_rdy),
    .deq_msg (q_deq_msg),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  assign respstream_msg = q_deq_msg;

  assign unused = &{1'b0, q_full, q_empty, q_count, req.addr[31:2+c_idx_w]};

endmodule

// File: tb/tb_proc_mem_responder.sv
// Directed self-checking bench for proc_mem_responder with hand-computed responses.
module tb_proc_mem_responder;
  import proc_mem_responder_pkg::*;

  logic        clk;
  logic        reset;
  logic        reqstream_val;
  logic        reqstream_rdy;
  logic [76:0] reqstream_msg;
  logic        respstream_val;
  logic        respstream_rdy;
  logic [46:0] respstream_msg;
  logic [2:0]  num_outstanding;

  int n_checks = 0;
  int n_errors = 0;

  proc_mem_responder #(
    .p_num_words  (256),
    .p_latency    (2),
    .p_resp_depth (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .reqstream_val   (reqstream_val),
    .reqstream_rdy   (reqstream_rdy),
    .reqstream_msg   (reqstream_msg),
    .respstream_val  (respstream_val),
    .respstream_rdy  (respstream_rdy),
    .respstream_msg  (respstream_msg),
    .num_outstanding (num_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [46:0] mk_resp(input logic [2:0] typ, input logic [7:0] opq,
                                          input logic [1:0] len, input logic [31:0] data);
    mem_resp_4B_t r;
    r.typ    = typ;
    r.opaque = opq;
    r.test   = 2'b00;
    r.len    = len;
    r.data   = data;
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [2:0] typ, input logic [7:0] opq, input logic [31:0] addr,
                      input logic [1:0] len, input logic [31:0] data);
    mem_req_4B_t r;
    bit done;
    r.typ = typ; r.opaque = opq; r.addr = addr; r.len = len; r.data = data;
    reqstream_msg = r;
    reqstream_val = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (reqstream_rdy) done = 1'b1;
      @(negedge clk);
    end
    reqstream_val = 1'b0;
    check("send_accepted", 64'(done), 64'(1));
  endtask

  // Waits (bounded) for a response with respstream_rdy high and checks it.
  task automatic recv(input string tag, input logic [46:0] exp, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      if (respstream_val) begin
        got = 1'b1;
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_val"}, 64'(got), 64'(1));
    if (got) begin
      check(tag, 64'(respstream_msg), 64'(exp));
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    reset          = 1'b0;
    reqstream_val  = 1'b0;
    reqstream_msg  = '0;
    respstream_rdy = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_resp_val", 64'(respstream_val), 64'(0));
    check("rst_outstanding", 64'(num_outstanding), 64'(0));
    check("rst_req_rdy", 64'(reqstream_rdy), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_req_rdy", 64'(reqstream_rdy), 64'(1));

    // INIT then READ with latency measurement
    respstream_rdy = 1'b1;
    send(c_type_init, 8'h01, 32'h200, 2'd0, 32'hDEADBEEF);
    recv("init_resp", mk_resp(c_type_init, 8'h01, 2'd0, 32'h0), lat);
    send(c_type_read, 8'h02, 32'h200, 2'd0, 32'h0);
    recv("read_deadbeef", mk_resp(c_type_read, 8'h02, 2'd0, 32'hDEADBEEF), lat);
    check("read_latency", 64'(lat), 64'(2));

    // Byte-lane write and sub-word reads
    send(c_type_write, 8'h03, 32'h200, 2'd0, 32'h11223344);
    recv("wr_full", mk_resp(c_type_write, 8'h03, 2'd0, 32'h0), lat);
    send(c_type_write, 8'h04, 32'h201, 2'd1, 32'h000000AA);
    recv("wr_byte", mk_resp(c_type_write, 8'h04, 2'd1, 32'h0), lat);
    send(c_type_read, 8'h05, 32'h200, 2'd0, 32'h0);
    recv("rd_merged", mk_resp(c_type_read, 8'h05, 2'd0, 32'h1122AA44), lat);
    send(c_type_read, 8'h06, 32'h203, 2'd1, 32'h0);
    recv("rd_byte3", mk_resp(c_type_read, 8'h06, 2'd1, 32'h00000011), lat);
    send(c_type_read, 8'h07, 32'h201, 2'd2, 32'h0);
    recv("rd_half_mid", mk_resp(c_type_read, 8'h07, 2'd2, 32'h000022AA), lat);
    send(c_type_read, 8'h08, 32'h202, 2'd0, 32'h0);
    recv("rd_clipped", mk_resp(c_type_read, 8'h08, 2'd0, 32'h00001122), lat);

    // Backpressure: fill credits, then drain in order
    for (int k = 0; k < 6; k++) begin
      send(c_type_write, 8'(8'h20 + k), 32'(4 * k), 2'd0, 32'hA0A00000 + 32'(k));
      recv("bp_prefill", mk_resp(c_type_write, 8'(8'h20 + k), 2'd0, 32'h0), lat);
    end
    respstream_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(c_type_read, 8'(8'h10 + k), 32'(4 * k), 2'd0, 32'h0);
    end
    check("bp_req_rdy_low", 64'(reqstream_rdy), 64'(0));
    check("bp_outstanding4", 64'(num_outstanding), 64'(4));
    repeat (3) @(negedge clk);
    check("bp_head_val", 64'(respstream_val), 64'(1));
    check("bp_head_stable", 64'(respstream_msg),
          64'(mk_resp(c_type_read, 8'h10, 2'd0, 32'hA0A00000)));
    check("bp_still_blocked", 64'(reqstream_rdy), 64'(0));
    fork
      begin
        for (int k = 4; k < 6; k++) begin
          send(c_type_read, 8'(8'h10 + k), 32'(4 * k), 2'd0, 32'h0);
        end
      end
      begin
        int l;
        respstream_rdy = 1'b1;
        for (int k = 0; k < 6; k++) begin
          recv("bp_drain", mk_resp(c_type_read, 8'(8'h10 + k), 2'd0, 32'hA0A00000 + 32'(k)), l);
          if (k < 4) check("bp_throughput", 64'(l), 64'(0));
        end
      end
    join
    @(negedge clk);
    check("bp_outstanding0", 64'(num_outstanding), 64'(0));

    // Address wrap modulo storage size
    send(c_type_read, 8'h30, 32'h400, 2'd0, 32'h0);
    recv("wrap_read", mk_resp(c_type_read, 8'h30, 2'd0, 32'hA0A00000), lat);
    send(c_type_write, 8'h31, 32'h400, 2'd0, 32'h55667788);
    recv("wrap_write", mk_resp(c_type_write, 8'h31, 2'd0, 32'h0), lat);
    send(c_type_read, 8'h32, 32'h000, 2'd0, 32'h0);
    recv("wrap_word0", mk_resp(c_type_read, 8'h32, 2'd0, 32'h55667788), lat);

    // Asynchronous reset with responses outstanding
    respstream_rdy = 1'b0;
    for (int k = 0; k < 3; k++) send(c_type_read, 8'(8'h40 + k), 32'h0, 2'd0, 32'h0);
    repeat (3) @(negedge clk);
    check("pre_rst_val", 64'(respstream_val), 64'(1));
    check("pre_rst_outstanding", 64'(num_outstanding), 64'(3));
    #2 reset = 1'b0;
    #1;
    check("async_rst_val", 64'(respstream_val), 64'(0));
    check("async_rst_outstanding", 64'(num_outstanding), 64'(0));
    check("async_rst_req_rdy", 64'(reqstream_rdy), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rerst_req_rdy", 64'(reqstream_rdy), 64'(1));
    respstream_rdy = 1'b1;
    repeat (4) @(negedge clk);
    check("rerst_discarded", 64'(respstream_val), 64'(0));
    send(c_type_read, 8'h50, 32'h0, 2'd0, 32'h0);
    recv("rerst_persist", mk_resp(c_type_read, 8'h50, 2'd0, 32'h55667788), lat);

    // Unknown type: echoed, zero data, no storage effect
    send(3'd5, 8'h7E, 32'h0, 2'd0, 32'hFFFFFFFF);
    recv("type5_resp", mk_resp(3'd5, 8'h7E, 2'd0, 32'h0), lat);
    send(c_type_read, 8'h51, 32'h0, 2'd0, 32'h0);
    recv("type5_no_write", mk_resp(c_type_read, 8'h51, 2'd0, 32'h55667788), lat);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
- Single-port test/target memory answering the processor's 4-byte memory request streams (imem or dmem) with mem_resp_4B_t responses.
- Accepts one request per cycle under val/rdy and performs reads, writes and init writes against internal word storage.
- Returns in-order responses after a fixed pipeline latency and buffers them under response backpressure.
- Sits at the far end of the processor's memory request and response streams in unit test harnesses and small SoC tiles.

Parameters:
- p_num_words, 256, storage depth in 32-bit words; power of two.
- p_latency, 2, cycles from request accept to earliest response valid; minimum 1.
- p_resp_depth, 4, maximum outstanding requests; also the response queue depth; minimum 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- reqstream_val  in  1  request valid.
- reqstream_rdy  out  1  request ready.
- reqstream_msg  in  77  mem_req_4B_t {type 3, opaque 8, addr 32, len 2, data 32}.
- respstream_val  out  1  response valid.
- respstream_rdy  in  1  response ready.
- respstream_msg  out  47  mem_resp_4B_t {type 3, opaque 8, test 2, len 2, data 32}.
- num_outstanding  out  $clog2(p_resp_depth+1)  accepted requests whose response has not yet been dequeued.

Behaviour:
- Handshakes:
  - A request is accepted on an edge where reqstream_val && reqstream_rdy.
  - A response is dequeued on an edge where respstream_val && respstream_rdy.
  - reqstream_rdy = (num_outstanding < p_resp_depth). It is a credit scheme, independent of reqstream_val.
  - Accept and dequeue on the same edge leave num_outstanding unchanged.
- Indexing and lanes:
  - Word index = addr[2 +: $clog2(p_num_words)]. Upper address bits are ignored, so out-of-range addresses wrap modulo the storage size.
  - Byte offset = addr[1:0]. len 0 means 4 bytes; len 1–3 means that many bytes.
  - Active lanes are bytes offset .. offset+nbytes-1, truncated at byte 3. Accesses that cross a word boundary are silently clipped.
- Request types:
  - READ (0): data = active bytes of the stored word, shifted down to bit 0 and zero-extended.
  - WRITE (1) and INIT (2): active bytes of req.data (taken from its low bytes) are written with byte enables. Response data = 0.
  - Any other type: no storage effect; response type echoed, data = 0.
- Access timing:
  - Storage is accessed at the accept edge, so the write is visible to a read accepted on the next edge.
  - Read data is sampled at accept. Read-after-write ordering therefore follows accept order exactly.
- Response fields: type, opaque and len are echoed from the request; test = 0.
- Latency pipeline:
  - p_latency stages of {valid, resp msg}, advancing every cycle and never stalled.
  - The final stage writes into the response queue; the credit scheme guarantees the queue has room.
  - A request accepted at edge t drives respstream_val high from edge t+p_latency, provided the queue is empty ahead of it.
  - Responses are strictly in order.
- Response queue:
  - FIFO of depth p_resp_depth. Output is taken directly from the head; no bypass beyond p_latency.
  - Full throughput of one response per cycle when respstream_rdy is held high.
- Reset (reset=0, asynchronous):
  - Clears pipeline valids, queue pointers and count.
  - Outputs: respstream_val=0, num_outstanding=0, reqstream_rdy=0 while asserted and 1 on the first cycle after release.
  - Storage contents are not reset.
  - Reset mid-operation discards all in-flight responses; writes already accepted persist.
- Boundaries:
  - Queue full and respstream_rdy=0 holds the head response stable.
  - Queue empty deasserts respstream_val.
  - Pointer wrap at depth uses modulo arithmetic, valid for non-power-of-two depth.

Decomposition:
- Shared package holds:
  - Existing mem_req_4B_t and mem_resp_4B_t types.
  - Type constants READ=0, WRITE=1, INIT=2.
  - Byte-lane mask helper function (offset, len -> 4-bit enable).
- One natural sub-module: proc_mem_resp_queue, a parameterised val/rdy FIFO with full, empty and count outputs.
- Storage, lane logic and the latency pipeline stay in the top module.

Test Plan:
- INIT addr 0x200 data 0xDEADBEEF, then READ addr 0x200 len 0, resp_rdy=1: read response data 0xDEADBEEF, arriving p_latency=2 cycles after accept; opaque echoed.
- WRITE addr 0x201 len 1 data 0x000000AA over word 0x11223344, then READ len 0: data 0x1122AA44; READ addr 0x203 len 1 returns 0x00000011.
- Back-to-back READs of 6 addresses with resp_rdy=0: reqstream_rdy drops after 4 accepts and num_outstanding=4. Raise resp_rdy: responses drain in order one per cycle, rdy reasserts, and the remaining 2 complete.
- READ addr 0x400 with p_num_words=256: returns contents of word 0 (wrap); WRITE to 0x400 alters word 0.
- Pulse reset low with 3 responses outstanding: respstream_val=0 and num_outstanding=0 immediately (asynchronously); after release, a READ returns the pre-reset written data.
- Response type 5 with opaque 0x7E: response type 5, data 0, opaque 0x7E; storage unchanged.
